// File: rtl/adc_window_energy.sv
// adc_window_energy: per-window sum-of-squares energy and peak |s| of offset-binary ADC samples,
// delivered on a valid/ready output with a sticky overrun flag.
module adc_window_energy #(
    parameter int DATA_W  = 12,
    parameter int WIN_LEN = 256,
    parameter int ACC_W   = 32
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic [ACC_W-1:0]  energy_o,
    output logic [DATA_W-1:0] peak_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o
);
    localparam int CW = $clog2(WIN_LEN);

    logic [CW-1:0]              cnt;
    logic                       v1, last1, v2, last2;
    logic signed [DATA_W-1:0]   s1;
    logic [2*DATA_W-1:0]        sq2;
    logic [DATA_W-1:0]          a2, pk, mag, pk_max;
    logic [ACC_W-1:0]           acc, acc_sum;
    logic signed [2*DATA_W-1:0] prod;

    // |-2^(DATA_W-1)| fits exactly once the result is read back as unsigned
    always_comb begin
        prod    = s1 * s1;
        mag     = s1[DATA_W-1] ? $unsigned(-s1) : $unsigned(s1);
        acc_sum = acc + ACC_W'(sq2);
        pk_max  = (a2 > pk) ? a2 : pk;
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            s1        <= '0;
            v2        <= 1'b0;
            last2     <= 1'b0;
            sq2       <= '0;
            a2        <= '0;
            acc       <= '0;
            pk        <= '0;
            energy_o  <= '0;
            peak_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (clear_i) begin
            cnt       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            acc       <= '0;
            pk        <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            v1 <= valid_i;
            if (valid_i) begin
                s1    <= {~data_i[DATA_W-1], data_i[DATA_W-2:0]};
                last1 <= (cnt == CW'(WIN_LEN - 1));
                cnt   <= cnt + CW'(1);
            end
            v2 <= v1;
            if (v1) begin
                sq2   <= $unsigned(prod);
                a2    <= mag;
                last2 <= last1;
            end
            // closing sample is folded into the result while acc/pk restart from zero
            if (v2 && last2) begin
                energy_o  <= acc_sum;
                peak_o    <= pk_max;
                valid_o   <= 1'b1;
                overrun_o <= overrun_o | (valid_o & ~ready_i);
                acc       <= '0;
                pk        <= '0;
            end else begin
                if (v2) begin
                    acc <= acc_sum;
                    pk  <= pk_max;
                end
                if (valid_o && ready_i)
                    valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_window_energy.sv
// tb_adc_window_energy: directed windows with a result scoreboard popped by an output monitor.
module tb_adc_window_energy;
    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] energy_o;
    logic [11:0] peak_o;
    logic        valid_o;
    logic        overrun_o;

    typedef struct {
        logic [31:0] e;
        logic [11:0] p;
    } res_t;

    res_t q[$];
    int   tests = 0;
    int   fails = 0;

    adc_window_energy dut (
        .sck(sck), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
        .energy_o(energy_o), .peak_o(peak_o), .valid_o(valid_o), .ready_i(ready_i),
        .overrun_o(overrun_o)
    );

    always #5 sck = ~sck;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge sck) begin
        if (rst_n && valid_o && ready_i) begin
            if (q.size() == 0) begin
                check("unexpected_result", energy_o, 32'hFFFF_FFFF);
            end else begin
                res_t r;
                r = q.pop_front();
                check("energy", energy_o, r.e);
                check("peak", 32'(peak_o), 32'(r.p));
            end
        end
    end

    task automatic send(input logic [11:0] d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b0;
            repeat (gap) begin
                @(posedge sck);
                #1;
            end
            data_i  = d;
            valid_i = 1'b1;
            @(posedge sck);
            #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sck);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        check("drain_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        check("rst_energy", energy_o, 0);
        check("rst_peak", 32'(peak_o), 0);

        // mid-scale, spaced, latency of exactly 3 cycles
        q.push_back('{32'd0, 12'd0});
        send(12'h800, 256, 13);
        check("lat_e0", 32'(valid_o), 0);
        tick(1);
        check("lat_e1", 32'(valid_o), 0);
        tick(1);
        check("lat_e2", 32'(valid_o), 1);
        drain();

        q.push_back('{32'd198697216, 12'd881});
        send(12'h48F, 256, 0);
        drain();
        check("b2b_overrun", 32'(overrun_o), 0);

        q.push_back('{32'h4000_0000, 12'd2048});
        q.push_back('{32'd1072693504, 12'd2047});
        send(12'h000, 256, 0);
        send(12'hFFF, 256, 0);
        drain();

        // overwrite of an unaccepted result
        ready_i = 1'b0;
        q.push_back('{32'd12544, 12'd7});
        send(12'h805, 256, 0);
        send(12'h7F9, 256, 0);
        tick(3);
        check("ovr_flag", 32'(overrun_o), 1);
        check("ovr_valid", 32'(valid_o), 1);
        check("ovr_hold_e", energy_o, 32'd12544);
        check("ovr_hold_p", 32'(peak_o), 32'd7);
        ready_i = 1'b1;
        tick(1);
        check("ovr_drop_valid", 32'(valid_o), 0);
        check("ovr_sticky", 32'(overrun_o), 1);
        check("ovr_queue", 32'(q.size()), 0);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        check("ovr_cleared", 32'(overrun_o), 0);

        // load coincident with accept
        ready_i = 1'b0;
        q.push_back('{32'd256, 12'd1});
        q.push_back('{32'd1024, 12'd2});
        send(12'h801, 256, 0);
        send(12'h7FE, 256, 0);
        tick(1);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        check("sim_valid", 32'(valid_o), 1);
        check("sim_e", energy_o, 32'd1024);
        check("sim_p", 32'(peak_o), 32'd2);
        check("sim_overrun", 32'(overrun_o), 0);
        ready_i = 1'b1;
        drain();

        // partial window discarded by clear
        send(12'h000, 100, 0);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        q.push_back('{32'd65536, 12'd16});
        send(12'h810, 256, 0);
        drain();

        // partial window discarded by reset
        send(12'hFFF, 100, 0);
        #2;
        rst_n = 1'b0;
        tick(2);
        check("rst2_valid", 32'(valid_o), 0);
        check("rst2_energy", energy_o, 0);
        check("rst2_peak", 32'(peak_o), 0);
        rst_n = 1'b1;
        tick(1);
        q.push_back('{32'd65536, 12'd16});
        send(12'h810, 256, 0);
        drain();
        tick(10);
        check("final_valid", 32'(valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_window_energy.md
Name: adc_window_energy

Overview:
- Downstream consumer of the ADC interface stage; runs in the same sck domain.
- Takes the 12-bit offset-binary samples and their single-cycle valid pulses from that stage.
- Converts each sample to signed and computes sum-of-squares energy and peak absolute value over fixed non-overlapping windows of WIN_LEN samples.
- Presents each window result on a valid/ready output with overrun detection. Feeds the receiver's signal-strength logic.

Parameters:
- DATA_W, 12: ADC sample width.
- WIN_LEN, 256: samples per window; power of two, >= 2.
- ACC_W, 32: energy width; must be >= 2*DATA_W + log2(WIN_LEN).

Ports:
- sck  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_i  in  DATA_W  offset-binary sample, 0x800 = mid-scale.
- valid_i  in  1  data_i valid this cycle; pulses may be back-to-back.
- clear_i  in  1  synchronous flush/restart.
- energy_o  out  ACC_W  window sum of s*s, unsigned.
- peak_o  out  DATA_W  window max |s|, unsigned, range 0..2048.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result when valid_o && ready_i.
- overrun_o  out  1  sticky: an unaccepted result was overwritten.

Behaviour:
- Reset (rst_n low, asynchronous): pipeline valids, sample counter, accumulator, peak register, energy_o, peak_o, valid_o and overrun_o all go to 0. Deassertion is released synchronously to sck by the top level.
- Stage 1 (on valid_i): s = {~data_i[MSB], data_i[MSB-1:0]} as signed DATA_W, i.e. data_i - 2048. Register s and a stage-1 valid.
- Stage 2: sq = s*s, unsigned 2*DATA_W bits. a = |s|, DATA_W bits unsigned; |-2048| = 2048 exactly, no wrap. Register both with a stage-2 valid and a last flag.
- Counter: 0..WIN_LEN-1, increments on each accepted valid_i, wraps to 0. The sample taken at count WIN_LEN-1 carries last=1 through the pipeline.
- Stage 3 (accumulate):
  - On stage-2 valid, acc += sq and pk = max(pk, a).
  - When last=1: load energy_o = acc + sq and peak_o = max(pk, a); set valid_o; in the same cycle set acc = 0 and pk = 0.
  - The first sample of the next window therefore starts from zero, and no sample is dropped.
- Latency: valid_o rises 3 sck cycles after the valid_i cycle that carried the window's last sample.
- Handshake:
  - valid_o stays high and energy_o/peak_o stay stable until valid_o && ready_i.
  - On that transfer edge, valid_o clears unless a new result loads in the same cycle.
- Simultaneous load and accept: the new result loads, valid_o stays 1, overrun_o is not set.
- Load while valid_o=1 and ready_i=0: the new result overwrites the old one, valid_o stays 1, and overrun_o is set to 1. overrun_o clears only on rst_n or clear_i.
- Overflow: with ACC_W >= 2*DATA_W + log2(WIN_LEN) the accumulator cannot overflow. No saturation logic.
- clear_i (synchronous; takes priority over valid_i and over a last-sample load that cycle):
  - Zeroes counter, pipeline valids, acc, pk, valid_o and overrun_o.
  - In-flight samples are discarded. The next valid_i starts a fresh window at count 0.
  - energy_o/peak_o retain their stale values, which are don't-care while valid_o=0.
- Reset or clear mid-window: a partial window is never emitted.
- Idle gaps in valid_i of any length have no effect on results.

Test Plan:
- 256 samples of 0x800 at a 14-cycle spacing, ready_i=1 -> one valid_o pulse with energy_o=0, peak_o=0, and valid_o rising exactly 3 cycles after the 256th valid_i.
- 256 back-to-back samples of 0x48F (s=-881) -> energy_o=198697216, peak_o=881, overrun_o=0.
- 256 of 0x000 followed by 256 of 0xFFF, ready_i=1 -> first result energy_o=0x40000000 with peak_o=2048; second result energy_o=1072693504 with peak_o=2047; no cross-window contamination.
- ready_i=0 across two full windows (0x800+5, then 0x800-7) -> overrun_o=1, outputs hold energy_o=12544, peak_o=7. Raise ready_i: valid_o drops the next cycle and overrun_o stays 1.
- Window completes on the same cycle ready_i accepts the previous result -> valid_o continuously 1, new values present, overrun_o=0.
- 100 samples, then clear_i for 1 cycle (also separately: rst_n pulse mid-window), then 256 samples of 0x810 -> no output from the partial window; single result energy_o=65536, peak_o=16.
